riscv_memsplit: RTL and testbench

Sequencer between the load/store unit and the data-memory bus interface for accesses that straddle a bus-word boundary. An accepted access is issued as one word-aligned bus beat, or as two consecutive word-aligned beats when it crosses into the next bus word. Byte enables and write data are steered per beat, and read data from both beats is merged back into one right-justified result. Sign extension and alignment-exception policy stay in the LSU; this block only sequences the bus.

---
 rtl/riscv_memsplit.sv | 270 +++++++++++++++++++++++++++
 tb/tb_riscv_memsplit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_memsplit.sv
// riscv_memsplit: sequences one LSU access onto the data-memory bus.
// An access that fits in one bus word goes out as a single aligned beat. One that
// crosses into the next word goes out as two consecutive aligned beats. Byte enables
// and store data are steered per beat. Read data from both beats is merged into one
// right-justified, zero-extended result.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_i/adr_i/size_i/we_i/d_i   LSU request (accepted when ready_o=1)
//   ready_o/ack_o/err_o/q_o   LSU handshake and load data
//   split_o                   current access uses two beats
//   mem_req_o/mem_adr_o/mem_we_o/mem_be_o/mem_d_o   bus request side
//   mem_ack_i/mem_err_i/mem_q_i                     bus response side
module riscv_memsplit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [PLEN-1:0]   adr_i,
    input  logic [2:0]        size_i,
    input  logic              we_i,
    input  logic [XLEN-1:0]   d_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic              err_o,
    output logic [XLEN-1:0]   q_o,
    output logic              split_o,
    output logic              mem_req_o,
    output logic [PLEN-1:0]   mem_adr_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_d_o,
    input  logic              mem_ack_i,
    input  logic              mem_err_i,
    input  logic [XLEN-1:0]   mem_q_i
);

    localparam int unsigned Bpw  = XLEN / 8;
    localparam int unsigned OffW = $clog2(Bpw);

    // biu_size_t encoding
    localparam logic [2:0] SizeByte  = 3'd0;
    localparam logic [2:0] SizeHword = 3'd1;
    localparam logic [2:0] SizeWord  = 3'd2;
    localparam logic [2:0] SizeDword = 3'd3;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBeat0 = 2'd1;
    localparam logic [1:0] StBeat1 = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    // Acceptance-time decode
    logic [OffW-1:0]     adr_off;
    int unsigned         n_bytes;
    logic                size_ok;
    logic                oversize;
    logic                split_acc;
    logic [2*Bpw-1:0]    be_mask;
    logic [2*Bpw-1:0]    be2;
    logic [2*XLEN-1:0]   d2;

    assign adr_off = adr_i[OffW-1:0];

    always_comb begin
        n_bytes = 0;
        size_ok = 1'b1;
        case (size_i)
            SizeByte:  n_bytes = 1;
            SizeHword: n_bytes = 2;
            SizeWord:  n_bytes = 4;
            SizeDword: n_bytes = 8;
            default:   size_ok = 1'b0;
        endcase
        be_mask = '0;
        for (int unsigned i = 0; i < 2 * Bpw; i++) begin
            be_mask[i] = (i < n_bytes);
        end
        be2       = be_mask << adr_off;
        d2        = {{XLEN{1'b0}}, d_i} << {adr_off, 3'b000};
        oversize  = !size_ok || (n_bytes > Bpw);
        split_acc = !oversize && ((32'(adr_off) + n_bytes) > Bpw);
    end

    // State
    logic [1:0]      state_q, state_d;
    logic            ready_q, ready_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] q_q, q_d;
    logic            split_q, split_d;
    logic            mem_req_q, mem_req_d;
    logic [PLEN-1:0] mem_adr_q, mem_adr_d;
    logic            mem_we_q, mem_we_d;
    logic [Bpw-1:0]  mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_d_q, mem_d_d;
    logic [OffW-1:0] off_q, off_d;
    logic [Bpw-1:0]  qmask_q, qmask_d;
    logic            we_q, we_d;
    logic [Bpw-1:0]  be_hi_q, be_hi_d;
    logic [XLEN-1:0] d_hi_q, d_hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    // Shift the two-word read window down to byte 0 and keep only the accessed bytes.
    // Stores report zero.
    function automatic logic [XLEN-1:0] merge_rd(input logic [2*XLEN-1:0] win,
                                                 input logic [OffW-1:0]   off,
                                                 input logic [Bpw-1:0]    mask,
                                                 input logic              we);
        logic [2*XLEN-1:0] sh;
        logic [XLEN-1:0]   res;
        sh  = win >> {off, 3'b000};
        res = '0;
        for (int unsigned b = 0; b < Bpw; b++) begin
            if (mask[b] && !we) begin
                res[8*b +: 8] = sh[8*b +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        q_d       = q_q;
        split_d   = split_q;
        mem_req_d = mem_req_q;
        mem_adr_d = mem_adr_q;
        mem_we_d  = mem_we_q;
        mem_be_d  = mem_be_q;
        mem_d_d   = mem_d_q;
        off_d     = off_q;
        qmask_d   = qmask_q;
        we_d      = we_q;
        be_hi_d   = be_hi_q;
        d_hi_d    = d_hi_q;
        lo_d      = lo_q;

        case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (req_i && ready_q) begin
                    ready_d = 1'b0;
                    off_d   = adr_off;
                    qmask_d = be_mask[Bpw-1:0];
                    we_d    = we_i;
                    split_d = split_acc;
                    q_d     = '0;
                    if (oversize) begin
                        // No bus traffic; report failure straight away.
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d   = StBeat0;
                        mem_req_d = 1'b1;
                        mem_adr_d = {adr_i[PLEN-1:OffW], {OffW{1'b0}}};
                        mem_we_d  = we_i;
                        mem_be_d  = be2[Bpw-1:0];
                        mem_d_d   = d2[XLEN-1:0];
                        be_hi_d   = be2[2*Bpw-1:Bpw];
                        d_hi_d    = d2[2*XLEN-1:XLEN];
                    end
                end
            end
            StBeat0: begin
                // Error wins over a simultaneous ack.
                if (mem_err_i) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = StResp;
                end else if (mem_ack_i) begin
                    lo_d = mem_q_i;
                    if (split_q) begin
                        state_d   = StBeat1;
                        mem_adr_d = mem_adr_q + PLEN'(Bpw);
                        mem_be_d  = be_hi_q;
                        mem_d_d   = d_hi_q;
                    end else begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        ack_d     = 1'b1;
                        q_d       = merge_rd({{XLEN{1'b0}}, mem_q_i}, off_q, qmask_q, we_q);
                        state_d   = StResp;
                    end
                end
            end
            StBeat1: begin
                if (mem_err_i) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                    state_d   = StResp;
                end else if (mem_ack_i) begin
                    // The high word comes straight from the bus; only the low word is buffered.
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    ack_d     = 1'b1;
                    q_d       = merge_rd({mem_q_i, lo_q}, off_q, qmask_q, we_q);
                    state_d   = StResp;
                end
            end
            StResp: begin
                // ack_o/err_o are high this cycle only.
                split_d = 1'b0;
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ready_q   <= 1'b1;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            q_q       <= '0;
            split_q   <= 1'b0;
            mem_req_q <= 1'b0;
            mem_adr_q <= '0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
            mem_d_q   <= '0;
            off_q     <= '0;
            qmask_q   <= '0;
            we_q      <= 1'b0;
            be_hi_q   <= '0;
            d_hi_q    <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            q_q       <= q_d;
            split_q   <= split_d;
            mem_req_q <= mem_req_d;
            mem_adr_q <= mem_adr_d;
            mem_we_q  <= mem_we_d;
            mem_be_q  <= mem_be_d;
            mem_d_q   <= mem_d_d;
            off_q     <= off_d;
            qmask_q   <= qmask_d;
            we_q      <= we_d;
            be_hi_q   <= be_hi_d;
            d_hi_q    <= d_hi_d;
            lo_q      <= lo_d;
        end
    end

    assign ready_o   = ready_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign q_o       = q_q;
    assign split_o   = split_q;
    assign mem_req_o = mem_req_q;
    assign mem_adr_o = mem_adr_q;
    assign mem_we_o  = mem_we_q;
    assign mem_be_o  = mem_be_q;
    assign mem_d_o   = mem_d_q;

endmodule

// File: tb/tb_riscv_memsplit.sv
// Bench for riscv_memsplit (XLEN=32). A bus responder checks each beat against an
// expected-beat queue; a response monitor pops an expected-response queue on every
// ack_o/err_o.
module tb_riscv_memsplit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PLEN = 32;

    logic            clk_i;
    logic            rst_i;
    logic            req_i;
    logic [31:0]     adr_i;
    logic [2:0]      size_i;
    logic            we_i;
    logic [31:0]     d_i;
    logic            ready_o;
    logic            ack_o;
    logic            err_o;
    logic [31:0]     q_o;
    logic            split_o;
    logic            mem_req_o;
    logic [31:0]     mem_adr_o;
    logic            mem_we_o;
    logic [3:0]      mem_be_o;
    logic [31:0]     mem_d_o;
    logic            mem_ack_i;
    logic            mem_err_i;
    logic [31:0]     mem_q_i;

    riscv_memsplit #(.XLEN(XLEN), .PLEN(PLEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .adr_i(adr_i), .size_i(size_i),
        .we_i(we_i), .d_i(d_i), .ready_o(ready_o), .ack_o(ack_o), .err_o(err_o),
        .q_o(q_o), .split_o(split_o), .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_d_o(mem_d_o),
        .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i), .mem_q_i(mem_q_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  be;
        logic [31:0] d;
        logic        we;
        int          waits;
        logic        err;
        logic [31:0] q;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] q;
        logic        split;
        logic        chk_split;
        logic        chk_lat;
    } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_beat_cyc = 0;
    int ack_cnt = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic push_beat(input logic [31:0] adr, input logic [3:0] be, input logic [31:0] d,
                             input logic we, input int waits, input logic err,
                             input logic [31:0] q);
        beat_t b;
        b.adr = adr; b.be = be; b.d = d; b.we = we; b.waits = waits; b.err = err; b.q = q;
        beat_q.push_back(b);
    endtask

    task automatic push_resp(input logic err, input logic [31:0] q, input logic split,
                             input logic chk_split, input logic chk_lat);
        resp_t r;
        r.err = err; r.q = q; r.split = split; r.chk_split = chk_split; r.chk_lat = chk_lat;
        resp_q.push_back(r);
    endtask

    // Bus responder: every cycle of a pending beat re-checks the fields (stall stability).
    initial begin
        int    wcnt;
        beat_t b;
        wcnt      = 0;
        mem_ack_i = 1'b0;
        mem_err_i = 1'b0;
        mem_q_i   = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            mem_err_i = 1'b0;
            if (!mem_req_o || rst_i) begin
                wcnt = 0;
            end else if (beat_q.size() == 0) begin
                check("unexpected_beat", {63'd0, mem_req_o}, 64'd0);
            end else begin
                b = beat_q[0];
                check("beat_adr", {32'd0, mem_adr_o}, {32'd0, b.adr});
                check("beat_be", {60'd0, mem_be_o}, {60'd0, b.be});
                check("beat_d", {32'd0, mem_d_o}, {32'd0, b.d});
                check("beat_we", {63'd0, mem_we_o}, {63'd0, b.we});
                if (wcnt >= b.waits) begin
                    mem_ack_i     = !b.err;
                    mem_err_i     = b.err;
                    mem_q_i       = b.q;
                    last_beat_cyc = cyc;
                    void'(beat_q.pop_front());
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Response monitor
    initial begin
        resp_t r;
        forever begin
            @(negedge clk_i);
            if (ack_o || err_o) begin
                check("ack_err_exclusive", {63'd0, ack_o && err_o}, 64'd0);
                if (ack_o) ack_cnt++;
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", {63'd0, ack_o | err_o}, 64'd0);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_err", {63'd0, err_o}, {63'd0, r.err});
                    check("resp_ack", {63'd0, ack_o}, {63'd0, !r.err});
                    if (!r.err) check("q_o", {32'd0, q_o}, {32'd0, r.q});
                    if (r.chk_split) check("split_o", {63'd0, split_o}, {63'd0, r.split});
                    if (r.chk_lat) check("resp_latency", 64'(cyc), 64'(last_beat_cyc + 1));
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (!ready_o) check("ready_timeout", {63'd0, ready_o}, 64'd1);
    endtask

    task automatic issue(input logic [31:0] adr, input logic [2:0] size, input logic we,
                         input logic [31:0] d);
        @(negedge clk_i);
        wait_ready();
        req_i = 1'b1; adr_i = adr; size_i = size; we_i = we; d_i = d;
        @(negedge clk_i);
        req_i = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((resp_q.size() != 0 || !ready_o) && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        check("done_pending_resps", 64'(resp_q.size()), 64'd0);
        check("done_pending_beats", 64'(beat_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

    initial begin
        int t;
        rst_i = 1'b1; req_i = 1'b0; adr_i = '0; size_i = '0; we_i = 1'b0; d_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", {63'd0, ready_o}, 64'd1);
        check("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
        check("rst_ack_err_split_we", {60'd0, ack_o, err_o, split_o, mem_we_o}, 64'd0);
        check("rst_adr_be", {28'd0, mem_adr_o, mem_be_o}, 64'd0);
        check("rst_d_q", {mem_d_o, q_o}, 64'd0);
        rst_i = 1'b0;

        // Split store WORD 0xAABBCCDD @0x1003
        push_beat(32'h1000, 4'b1000, 32'hDD000000, 1'b1, 1, 1'b0, 32'hDEADBEEF);
        push_beat(32'h1004, 4'b0111, 32'h00AABBCC, 1'b1, 2, 1'b0, 32'hDEADBEEF);
        push_resp(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        issue(32'h1003, 3'd2, 1'b1, 32'hAABBCCDD);
        wait_done();

        // Split load HWORD @0x2003
        push_beat(32'h2000, 4'b1000, 32'hFE000000, 1'b0, 0, 1'b0, 32'h11223344);
        push_beat(32'h2004, 4'b0001, 32'h000000CA, 1'b0, 1, 1'b0, 32'h55667788);
        push_resp(1'b0, 32'h00008811, 1'b1, 1'b1, 1'b1);
        issue(32'h2003, 3'd1, 1'b0, 32'h0000CAFE);
        wait_done();

        // Single-beat load HWORD @0x2001
        push_beat(32'h2000, 4'b0110, 32'h00BEEF00, 1'b0, 0, 1'b0, 32'h11223344);
        push_resp(1'b0, 32'h00002233, 1'b0, 1'b1, 1'b1);
        issue(32'h2001, 3'd1, 1'b0, 32'h0000BEEF);
        wait_done();

        // Split store with error on beat0: beat1 never issued
        push_beat(32'h1000, 4'b1100, 32'h56780000, 1'b1, 1, 1'b1, 32'h0);
        push_resp(1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
        issue(32'h1002, 3'd2, 1'b1, 32'h12345678);
        wait_done();

        // Oversize DWORD: err_o the cycle after acceptance, no bus traffic
        push_resp(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(32'h3000, 3'd3, 1'b0, 32'h0);
        check("dword_err_next", {63'd0, err_o}, 64'd1);
        check("dword_no_mem_req", {63'd0, mem_req_o}, 64'd0);
        wait_done();

        // Unknown size
        push_resp(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(32'h3004, 3'd5, 1'b0, 32'h0);
        check("badsize_err_next", {63'd0, err_o}, 64'd1);
        wait_done();

        // Reset while BEAT1 is stalled
        push_beat(32'h4000, 4'b1100, 32'h0, 1'b0, 0, 1'b0, 32'h01020304);
        push_beat(32'h4004, 4'b0011, 32'h0, 1'b0, 1000, 1'b0, 32'h05060708);
        issue(32'h4002, 3'd2, 1'b0, 32'h0);
        t = 0;
        while (!(mem_req_o && mem_adr_o == 32'h4004) && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        check("beat1_reached", {63'd0, mem_req_o}, 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_mid_mem_req", {63'd0, mem_req_o}, 64'd0);
        check("rst_mid_ready", {63'd0, ready_o}, 64'd1);
        check("rst_mid_ack", {63'd0, ack_o}, 64'd0);
        beat_q.delete();
        repeat (4) @(negedge clk_i);

        // Back-to-back BYTE loads with req_i held high
        for (int k = 0; k < 3; k++) begin
            push_beat(32'h5000, 4'b0001 << k, 32'h0, 1'b0, 2, 1'b0, 32'hA1B2C3D4);
        end
        push_resp(1'b0, 32'h000000D4, 1'b0, 1'b1, 1'b1);
        push_resp(1'b0, 32'h000000C3, 1'b0, 1'b1, 1'b1);
        push_resp(1'b0, 32'h000000B2, 1'b0, 1'b1, 1'b1);
        ack_cnt = 0;
        req_i = 1'b1; size_i = 3'd0; we_i = 1'b0; d_i = '0;
        for (int k = 0; k < 3; k++) begin
            adr_i = 32'h5000 + 32'(k);
            wait_ready();
            @(posedge clk_i);
            @(negedge clk_i);
        end
        req_i = 1'b0;
        wait_done();
        check("b2b_ack_count", 64'(ack_cnt), 64'd3);

        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
